// File: rtl/pipe_out_frame_tx.sv
// ---------------------------------------------------------------------------
// pipe_out_frame_tx
//
// Buffers 128-bit result frames in a small FIFO and hands them out one
// 32-bit word per ep_read strobe to a pipe-out endpoint, most-significant
// word first. A one-cycle trigger pulse marks every accepted frame.
//
// Handshake: a frame is pushed on any cycle where frame_valid and
// frame_ready are both high; frame_ready depends on registered state only,
// and a producer seeing frame_ready low keeps frame_valid and frame_data
// stable until the push happens.
//
// Optional feature macro: PIPE_OUT_TX_ERR_CNT_EN
//   defined   -> err_count counts underflow reads, saturating at 16'hFFFF
//   undefined -> err_count is tied to zero
//
// Ports
//   clk              in   single clock (okClk domain)
//   rst              in   synchronous active-high reset
//   frame_data       in   128-bit frame, word3=[127:96] .. word0=[31:0]
//   frame_valid      in   producer offers frame_data
//   frame_ready      out  block can accept a frame this cycle
//   ep_read          in   pipe-out read strobe, one word per cycle
//   ep_datain        out  registered word returned to the endpoint
//   frame_avail_trig out  one-cycle pulse the cycle after each push
//   frame_count      out  frames stored, including a partially read head
//   underflow_err    out  sticky: a read happened while empty
//   err_count        out  number of underflow reads (see macro above)
// ---------------------------------------------------------------------------
module pipe_out_frame_tx #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [127:0]             frame_data,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    input  logic                     ep_read,
    output logic [31:0]              ep_datain,
    output logic                     frame_avail_trig,
    output logic [$clog2(DEPTH):0]   frame_count,
    output logic                     underflow_err,
    output logic [15:0]              err_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [127:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_read_idx;
    logic [31:0]   r_datain;
    logic          r_trig;
    logic          r_underflow;

    logic          w_push;
    logic          w_empty;
    logic          w_rd;
    logic          w_pop;
    logic          w_underflow_rd;
    logic [31:0]   w_head_word;

    // Ready comes from the registered count only, so a pop in the same
    // cycle never opens the door early; the freed slot shows up next cycle.
    assign frame_ready    = (r_count < CW'(DEPTH)) && !rst;
    assign w_push         = frame_valid && frame_ready;
    assign w_empty        = (r_count == '0);
    assign w_rd           = ep_read && !w_empty;
    assign w_underflow_rd = ep_read && w_empty;
    assign w_pop          = w_rd && (r_read_idx == 2'd0);
    assign w_head_word    = r_mem[r_rd_ptr][{r_read_idx, 5'b0} +: 32];

    // Frame storage carries no reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= frame_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_read_idx  <= 2'd3;
            r_datain    <= '0;
            r_trig      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_trig <= w_push;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end

            // Reads address the head frame, word3 first; the word0 read pops.
            if (w_rd) begin
                r_datain <= w_head_word;
                if (w_pop) begin
                    r_read_idx <= 2'd3;
                    r_rd_ptr   <= r_rd_ptr + PW'(1);
                end else begin
                    r_read_idx <= r_read_idx - 2'd1;
                end
            end else if (w_underflow_rd) begin
                // A push landing this same cycle is not visible yet: no bypass.
                r_datain    <= '0;
                r_underflow <= 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PIPE_OUT_TX_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_underflow_rd && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 16'd0;
`endif

    assign ep_datain        = r_datain;
    assign frame_avail_trig = r_trig;
    assign frame_count      = r_count;
    assign underflow_err    = r_underflow;

endmodule

// File: tb/tb_pipe_out_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_pipe_out_frame_tx
//
// Directed bench for pipe_out_frame_tx (DEPTH=4): single-frame readout,
// full/back-pressure behaviour, underflow, push+read on empty, mid-frame
// reset, and a streamed run across pointer wrap checked against a word
// queue. Inputs are driven 1 time unit after the rising edge, outputs are
// checked at the same point.
// ---------------------------------------------------------------------------
module tb_pipe_out_frame_tx;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk;
    logic           rst;
    logic [127:0]   frame_data;
    logic           frame_valid;
    logic           frame_ready;
    logic           ep_read;
    logic [31:0]    ep_datain;
    logic           frame_avail_trig;
    logic [CW-1:0]  frame_count;
    logic           underflow_err;
    logic [15:0]    err_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

`ifdef PIPE_OUT_TX_ERR_CNT_EN
    localparam logic [15:0] ERR_AFTER_ONE = 16'd1;
`else
    localparam logic [15:0] ERR_AFTER_ONE = 16'd0;
`endif

    pipe_out_frame_tx #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_data       (frame_data),
        .frame_valid      (frame_valid),
        .frame_ready      (frame_ready),
        .ep_read          (ep_read),
        .ep_datain        (ep_datain),
        .frame_avail_trig (frame_avail_trig),
        .frame_count      (frame_count),
        .underflow_err    (underflow_err),
        .err_count        (err_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        frame_valid = 1'b0;
        ep_read     = 1'b0;
        frame_data  = '0;
        tick();
        tick();
        check("ready_in_reset", 32'(frame_ready), 32'd0);
        rst = 1'b0;
        #1;
    endtask

    // Frame i: word k = 32'hF000_0000 | i<<8 | k
    function automatic logic [127:0] mk_frame(input int i);
        logic [31:0] b;
        b = 32'hF000_0000 | (32'(i) << 8);
        return {b | 32'd3, b | 32'd2, b | 32'd1, b};
    endfunction

    task automatic push_one(input logic [127:0] d);
        frame_data  = d;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [31:0] exp);
        ep_read = 1'b1;
        tick();
        ep_read = 1'b0;
        check(tag, ep_datain, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] f;
        rst         = 1'b1;
        frame_valid = 1'b0;
        ep_read     = 1'b0;
        frame_data  = '0;

        // Reset state
        do_reset();
        check("rst_count",    32'(frame_count),      32'd0);
        check("rst_datain",   ep_datain,             32'd0);
        check("rst_trig",     32'(frame_avail_trig), 32'd0);
        check("rst_uflow",    32'(underflow_err),    32'd0);
        check("rst_errcnt",   32'(err_count),        32'd0);
        check("rst_ready",    32'(frame_ready),      32'd1);

        // Single frame, MSW first
        push_one(128'h00000004_00000003_00000002_00000001);
        check("one_trig",  32'(frame_avail_trig), 32'd1);
        check("one_count", 32'(frame_count),      32'd1);
        tick();
        check("one_trig_off", 32'(frame_avail_trig), 32'd0);
        ep_read = 1'b1;
        for (int k = 4; k >= 1; k--) begin
            tick();
            check("one_word", ep_datain, 32'(k));
            check("one_cnt_rd", 32'(frame_count), (k == 1) ? 32'd0 : 32'd1);
        end
        ep_read = 1'b0;
        tick();
        check("one_hold", ep_datain, 32'd1);
        check("one_no_trig", 32'(frame_avail_trig), 32'd0);

        // Underflow on empty
        read_word("uflow_data", 32'd0);
        check("uflow_flag",  32'(underflow_err), 32'd1);
        check("uflow_err",   32'(err_count),     32'(ERR_AFTER_ONE));
        check("uflow_count", 32'(frame_count),   32'd0);
        tick();
        tick();
        check("uflow_sticky", 32'(underflow_err), 32'd1);

        // Fill to DEPTH, 5th frame held back, freed slot taken next cycle
        do_reset();
        check("fill_uflow_clr", 32'(underflow_err), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            frame_data  = mk_frame(i);
            frame_valid = 1'b1;
            check("fill_ready", 32'(frame_ready), 32'd1);
            tick();
        end
        check("full_count", 32'(frame_count), 32'd4);
        check("full_ready", 32'(frame_ready), 32'd0);
        frame_data = mk_frame(4);
        tick();
        check("full_reject_cnt",  32'(frame_count),      32'd4);
        check("full_reject_trig", 32'(frame_avail_trig), 32'd0);
        // frame_valid stays high while draining the head frame; the last
        // word read coincides with a rejected push
        f = mk_frame(0);
        ep_read = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            tick();
            check("full_word", ep_datain, f[32*k +: 32]);
        end
        ep_read = 1'b0;
        check("pop_count",  32'(frame_count),      32'd3);
        check("pop_ready",  32'(frame_ready),      32'd1);
        check("pop_trig",   32'(frame_avail_trig), 32'd0);
        tick();
        frame_valid = 1'b0;
        check("refill_count", 32'(frame_count),      32'd4);
        check("refill_trig",  32'(frame_avail_trig), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            f = mk_frame(i);
            for (int k = 3; k >= 0; k--) begin
                read_word("drain_word", f[32*k +: 32]);
            end
        end
        check("drain_count", 32'(frame_count), 32'd0);
        check("drain_no_uflow", 32'(underflow_err), 32'd0);

        // Push and read on empty in the same cycle: read is an underflow
        do_reset();
        frame_data  = mk_frame(7);
        frame_valid = 1'b1;
        ep_read     = 1'b1;
        tick();
        frame_valid = 1'b0;
        ep_read     = 1'b0;
        check("bypass_data",  ep_datain,              32'd0);
        check("bypass_uflow", 32'(underflow_err),     32'd1);
        check("bypass_count", 32'(frame_count),       32'd1);
        f = mk_frame(7);
        for (int k = 3; k >= 0; k--) begin
            read_word("bypass_word", f[32*k +: 32]);
        end

        // Reset mid-frame
        do_reset();
        push_one(mk_frame(9));
        f = mk_frame(9);
        read_word("mid_w3", f[127:96]);
        read_word("mid_w2", f[95:64]);
        rst = 1'b1;
        tick();
        check("mid_rst_data",  ep_datain,              32'd0);
        check("mid_rst_count", 32'(frame_count),       32'd0);
        check("mid_rst_trig",  32'(frame_avail_trig),  32'd0);
        check("mid_rst_uflow", 32'(underflow_err),     32'd0);
        check("mid_rst_err",   32'(err_count),         32'd0);
        rst = 1'b0;
        push_one(128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        read_word("mid_A", 32'hAAAAAAAA);
        read_word("mid_B", 32'hBBBBBBBB);
        read_word("mid_C", 32'hCCCCCCCC);
        read_word("mid_D", 32'hDDDDDDDD);

        // Streamed random frames across pointer wrap
        begin
            int pushed = 0;
            int cycles = 0;
            int m_count = 0;
            int m_idx = 3;
            logic [127:0] cur;
            logic do_push;
            logic do_rd;
            do_reset();
            exp_q.delete();
            cur = {$urandom, $urandom, $urandom, $urandom};
            while ((pushed < 3 * DEPTH || exp_q.size() > 0) && cycles < 2000) begin
                frame_valid = (pushed < 3 * DEPTH);
                frame_data  = cur;
                ep_read     = (m_count > 0) && ($urandom_range(0, 3) != 0);
                check("rand_ready", 32'(frame_ready), 32'(m_count < DEPTH));
                do_push = frame_valid && (m_count < DEPTH);
                do_rd   = ep_read;
                tick();
                if (do_rd) begin
                    check("rand_word", ep_datain, exp_q.pop_front());
                    if (m_idx == 0) begin
                        m_idx = 3;
                        m_count--;
                    end else begin
                        m_idx--;
                    end
                end
                if (do_push) begin
                    for (int k = 3; k >= 0; k--) exp_q.push_back(cur[32*k +: 32]);
                    m_count++;
                    pushed++;
                    cur = {$urandom, $urandom, $urandom, $urandom};
                end
                check("rand_count", 32'(frame_count), 32'(m_count));
                cycles++;
            end
            frame_valid = 1'b0;
            ep_read     = 1'b0;
            if (cycles >= 2000) check("rand_timeout", 32'd0, 32'd1);
            check("rand_uflow", 32'(underflow_err), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
